// File: rtl/trace_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg
// Shared constants and types for the instruction-trace streamer.
//   NOP_INSTR / ZERO_INSTR : instruction words treated as filler by the filter
//   WFI_INSTR              : wait-for-interrupt encoding, used by upstream
//                            qualification logic that drives write_enable
//   trace_pkt_t            : {pc, instr} packet at the default PC width
//   is_filler_instr()      : filter predicate shared by RTL users
// ---------------------------------------------------------------------------
package trace_pkg;

  localparam int DEFAULT_XLEN       = 64;
  localparam int DEFAULT_FIFO_DEPTH = 16;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] ZERO_INSTR = 32'h0000_0000;
  localparam logic [31:0] WFI_INSTR  = 32'h1050_0073;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [31:0]             instr;
  } trace_pkt_t;

  function automatic logic is_filler_instr(input logic [31:0] instr);
    return (instr == NOP_INSTR) || (instr == ZERO_INSTR);
  endfunction

endpackage

// File: rtl/trace_axis_fifo.sv
// ---------------------------------------------------------------------------
// trace_axis_fifo
// Synchronous single-clock FIFO holding trace packets plus a tlast tag bit.
// Head is presented combinationally (first-word fall-through) and forced to
// zero while empty so the stream output never shows stale storage.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_push     : request to write i_data at the tail
//   i_pop      : head consumed this cycle (ignored while empty)
//   i_data     : WIDTH-bit entry to write
//   o_data     : head entry, zero while empty
//   o_empty    : no entries stored
//   o_full     : DEPTH entries stored
//   o_accept   : i_push was accepted this cycle
// A push while full is accepted only when a pop frees the slot in the same
// cycle; otherwise it is refused (o_accept low).
// ---------------------------------------------------------------------------
module trace_axis_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_accept
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // Full-and-popping still has a free slot by the end of the cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_accept  = w_do_push;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers are AW bits wide and DEPTH is a power of two, so natural
  // overflow implements the modulo-DEPTH wrap; r_count separates full/empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/trace_axis_streamer.sv
// ---------------------------------------------------------------------------
// trace_axis_streamer
// Packs retired {pc, instr} pairs into an AXI-Stream master through a FIFO,
// with burst framing via tlast, a filler-instruction filter and a general
// purpose edge detector.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   instr, pc, pc_valid      : retired instruction, its PC, retire strobe
//   write_enable             : upstream qualification gate
//   force_tlast              : close the burst with the packet written now
//   tlast_interval           : packets per burst, 0 disables count framing
//   sig, sig_pos_edge/neg    : edge detector input and one-cycle pulses
//   drop_instr               : filter verdict for the current instr
//   M_AXIS_*                 : stream master (tvalid/tready/tdata/tlast)
//   overflow                 : sticky, a push was lost to a full FIFO
// Build option: define TRACE_FILTER_EN to drop NOP (0x13) and all-zero words;
// without it drop_instr is tied low and every qualified retire is pushed.
//
// Handshake: a beat transfers on a rising edge where M_AXIS_tvalid and
// M_AXIS_tready are both high. tvalid never depends on tready, and
// tdata/tlast stay constant while tvalid is high and tready is low.
// ---------------------------------------------------------------------------
module trace_axis_streamer
  import trace_pkg::*;
#(
  parameter int XLEN       = DEFAULT_XLEN,
  parameter int DATA_WIDTH = XLEN + 32,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic [XLEN-1:0]       pc,
  input  logic                  pc_valid,
  input  logic                  write_enable,
  input  logic                  force_tlast,
  input  logic [31:0]           tlast_interval,
  input  logic                  sig,
  output logic                  sig_pos_edge,
  output logic                  sig_neg_edge,
  output logic                  drop_instr,
  output logic                  M_AXIS_tvalid,
  input  logic                  M_AXIS_tready,
  output logic [DATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                  M_AXIS_tlast,
  output logic                  overflow
);

  logic        r_sig_q;
  logic [31:0] r_cnt;
  logic        r_overflow;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_accept;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_interval_hit;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_packet;
  logic [DATA_WIDTH:0]   w_head;

  // Edge detector
  assign sig_pos_edge = sig & ~r_sig_q;
  assign sig_neg_edge = ~sig & r_sig_q;

  // Filler filter
`ifdef TRACE_FILTER_EN
  assign drop_instr = is_filler_instr(instr);
`else
  assign drop_instr = 1'b0;
`endif

  assign w_push = pc_valid & write_enable & ~drop_instr;
  assign w_pop  = M_AXIS_tvalid & M_AXIS_tready;

  // The interval is compared live against the running count, so a new value
  // takes effect on the next push; if the count is already past it, only
  // force_tlast or the 32-bit wrap can close the burst.
  assign w_interval_hit = (tlast_interval != 32'd0) &&
                          (r_cnt == (tlast_interval - 32'd1));
  assign w_last   = force_tlast | w_interval_hit;
  assign w_packet = DATA_WIDTH'({pc, instr});

  trace_axis_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_data   ({w_last, w_packet}),
    .o_data   (w_head),
    .o_empty  (w_empty),
    .o_full   (w_full),
    .o_accept (w_accept)
  );

  assign M_AXIS_tvalid = ~w_empty;
  assign M_AXIS_tdata  = w_head[DATA_WIDTH-1:0];
  assign M_AXIS_tlast  = w_head[DATA_WIDTH];
  assign overflow      = r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sig_q    <= 1'b0;
      r_cnt      <= 32'd0;
      r_overflow <= 1'b0;
    end else begin
      r_sig_q <= sig;
      // Only packets that actually land in the FIFO advance the burst.
      if (w_accept) begin
        r_cnt <= w_last ? 32'd0 : r_cnt + 32'd1;
      end
      if (w_push & ~w_accept) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // w_full is kept visible for debug probing of the FIFO state.
  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_trace_axis_streamer.sv
module tb_trace_axis_streamer;

  localparam int XLEN  = 64;
  localparam int DW    = XLEN + 32;
  localparam int DEPTH = 16;
`ifdef TRACE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            write_enable;
  logic            force_tlast;
  logic [31:0]     tlast_interval;
  logic            sig;
  logic            sig_pos_edge;
  logic            sig_neg_edge;
  logic            drop_instr;
  logic            M_AXIS_tvalid;
  logic            M_AXIS_tready;
  logic [DW-1:0]   M_AXIS_tdata;
  logic            M_AXIS_tlast;
  logic            overflow;

  trace_axis_streamer #(
    .XLEN       (XLEN),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .instr          (instr),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .write_enable   (write_enable),
    .force_tlast    (force_tlast),
    .tlast_interval (tlast_interval),
    .sig            (sig),
    .sig_pos_edge   (sig_pos_edge),
    .sig_neg_edge   (sig_neg_edge),
    .drop_instr     (drop_instr),
    .M_AXIS_tvalid  (M_AXIS_tvalid),
    .M_AXIS_tready  (M_AXIS_tready),
    .M_AXIS_tdata   (M_AXIS_tdata),
    .M_AXIS_tlast   (M_AXIS_tlast),
    .overflow       (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          errors = 0;
  int          checks = 0;
  logic [DW:0] exp_q[$];   // {last, pc, instr}
  int          seq = 0;

  typedef struct {
    logic        rst_before;
    logic        frc;
    logic [31:0] intv;
    logic        exp_last;
  } push_vec_t;

  typedef struct {
    logic [31:0] ins;
    logic        exp_drop;
  } filt_vec_t;

  typedef struct {
    logic s;
    logic exp_pos;
    logic exp_neg;
  } edge_vec_t;

  push_vec_t pvecs[$];
  filt_vec_t fvecs[$];
  edge_vec_t evecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: compare any beat transferring on the coming edge, then step
  // to 1 time unit after the edge, where inputs get driven.
  task automatic tick();
    logic [DW:0] e;
    @(negedge clk);
    if (M_AXIS_tvalid && M_AXIS_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pkt: got %0h with nothing expected", M_AXIS_tdata);
      end else begin
        e = exp_q.pop_front();
        check("pkt_data", M_AXIS_tdata, e[DW-1:0]);
        check("pkt_last", M_AXIS_tlast, e[DW]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_one(input logic frc, input logic [31:0] intv,
                          input logic exp_push, input logic exp_last);
    logic [31:0] r;
    r = $urandom();
    seq++;
    pc             = 64'h8000_0000 + 64'(seq) * 4;
    instr          = {r[31:7], 7'h33};   // never a filler word
    pc_valid       = 1'b1;
    write_enable   = 1'b1;
    force_tlast    = frc;
    tlast_interval = intv;
    if (exp_push) exp_q.push_back({exp_last, pc, instr});
    tick();
    pc_valid    = 1'b0;
    force_tlast = 1'b0;
  endtask

  task automatic push_raw(input logic [31:0] ins, input logic we, input logic exp_push);
    seq++;
    pc             = 64'h8000_0000 + 64'(seq) * 4;
    instr          = ins;
    pc_valid       = 1'b1;
    write_enable   = we;
    force_tlast    = 1'b0;
    tlast_interval = 32'd0;
    if (exp_push) exp_q.push_back({1'b0, pc, instr});
    tick();
    pc_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    M_AXIS_tready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d packets outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
    tick();
    check({name, "_tvalid_empty"}, M_AXIS_tvalid, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [DW-1:0] held;

    rst = 1'b1; instr = 32'h33; pc = '0; pc_valid = 1'b0; write_enable = 1'b0;
    force_tlast = 1'b0; tlast_interval = 32'd0; sig = 1'b0; M_AXIS_tready = 1'b0;

    // burst framing vectors: interval 4; interval change mid-burst; force_tlast
    for (int i = 0; i < 10; i++)
      pvecs.push_back('{rst_before: (i == 0), frc: 1'b0, intv: 32'd4, exp_last: (i == 3 || i == 7)});
    for (int i = 0; i < 3; i++)
      pvecs.push_back('{rst_before: (i == 0), frc: 1'b0, intv: 32'd4, exp_last: 1'b0});
    pvecs.push_back('{rst_before: 1'b0, frc: 1'b0, intv: 32'd2, exp_last: 1'b0});  // cnt 3
    pvecs.push_back('{rst_before: 1'b0, frc: 1'b0, intv: 32'd2, exp_last: 1'b0});  // cnt 4
    pvecs.push_back('{rst_before: 1'b0, frc: 1'b1, intv: 32'd2, exp_last: 1'b1});  // forced
    pvecs.push_back('{rst_before: 1'b0, frc: 1'b0, intv: 32'd2, exp_last: 1'b0});  // cnt 0
    pvecs.push_back('{rst_before: 1'b0, frc: 1'b0, intv: 32'd2, exp_last: 1'b1});  // cnt 1
    for (int i = 0; i < 10; i++)
      pvecs.push_back('{rst_before: (i == 0), frc: (i == 1), intv: 32'd8, exp_last: (i == 1 || i == 9)});

    fvecs.push_back('{ins: 32'h0000_0013, exp_drop: FILT});
    fvecs.push_back('{ins: 32'h0000_0000, exp_drop: FILT});
    fvecs.push_back('{ins: 32'h0000_0033, exp_drop: 1'b0});
    fvecs.push_back('{ins: 32'h1050_0073, exp_drop: 1'b0});
    fvecs.push_back('{ins: 32'h0000_0093, exp_drop: 1'b0});
    fvecs.push_back('{ins: 32'h0010_0013, exp_drop: 1'b0});

    evecs.push_back('{s: 1'b1, exp_pos: 1'b1, exp_neg: 1'b0});
    evecs.push_back('{s: 1'b1, exp_pos: 1'b0, exp_neg: 1'b0});
    evecs.push_back('{s: 1'b0, exp_pos: 1'b0, exp_neg: 1'b1});
    evecs.push_back('{s: 1'b0, exp_pos: 1'b0, exp_neg: 1'b0});

    // reset state
    tick(); tick();
    check("rst_tvalid", M_AXIS_tvalid, 1'b0);
    check("rst_tdata", M_AXIS_tdata, '0);
    check("rst_tlast", M_AXIS_tlast, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_pos_edge", sig_pos_edge, 1'b0);
    check("rst_neg_edge", sig_neg_edge, 1'b0);
    rst = 1'b0;
    tick();

    // edge detector
    foreach (evecs[i]) begin
      sig = evecs[i].s;
      #1;
      check("sig_pos_edge", sig_pos_edge, evecs[i].exp_pos);
      check("sig_neg_edge", sig_neg_edge, evecs[i].exp_neg);
      tick();
    end

    // filter verdict (combinational, no retire)
    foreach (fvecs[i]) begin
      instr = fvecs[i].ins;
      #1;
      check("drop_instr", drop_instr, fvecs[i].exp_drop);
      tick();
    end

    // filter effect on the stream, and the write_enable gate
    M_AXIS_tready = 1'b1;
    push_raw(32'h0000_0013, 1'b1, !FILT);
    push_raw(32'h0000_0000, 1'b1, !FILT);
    push_raw(32'h0000_00b3, 1'b0, 1'b0);
    push_raw(32'h0000_00b3, 1'b1, 1'b1);
    drain("filter");

    // burst framing table
    foreach (pvecs[i]) begin
      if (pvecs[i].rst_before) begin
        drain("framing");
        do_reset();
        M_AXIS_tready = 1'b1;
      end
      push_one(pvecs[i].frc, pvecs[i].intv, 1'b1, pvecs[i].exp_last);
    end
    drain("framing");

    // full FIFO: overflow, stall stability, push+pop when full, in-order drain
    do_reset();
    M_AXIS_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_one(1'b0, 32'd0, 1'b1, 1'b0);
    check("full_overflow_clear", overflow, 1'b0);
    check("full_tvalid", M_AXIS_tvalid, 1'b1);
    push_one(1'b0, 32'd0, 1'b0, 1'b0);
    push_one(1'b0, 32'd0, 1'b0, 1'b0);
    check("overflow_set", overflow, 1'b1);
    held = exp_q[0][DW-1:0];
    check("stall_head", M_AXIS_tdata, held);
    tick(); tick();
    check("stall_hold", M_AXIS_tdata, held);
    M_AXIS_tready = 1'b1;
    push_one(1'b0, 32'd0, 1'b1, 1'b0);   // full with simultaneous pop
    drain("overflow");
    check("empty_tdata_zero", M_AXIS_tdata, '0);
    check("empty_tlast_zero", M_AXIS_tlast, 1'b0);
    check("overflow_sticky", overflow, 1'b1);

    // reset with queued packets, then first-push latency and new burst
    M_AXIS_tready = 1'b0;
    for (int i = 0; i < 5; i++) push_one(1'b0, 32'd0, 1'b1, 1'b0);
    check("queued_tvalid", M_AXIS_tvalid, 1'b1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("midrst_tvalid", M_AXIS_tvalid, 1'b0);
    check("midrst_tdata", M_AXIS_tdata, '0);
    check("midrst_overflow", overflow, 1'b0);
    rst = 1'b0;
    push_one(1'b0, 32'd1, 1'b1, 1'b1);
    check("latency_tvalid", M_AXIS_tvalid, 1'b1);
    check("latency_tdata", M_AXIS_tdata, exp_q[0][DW-1:0]);
    check("latency_tlast", M_AXIS_tlast, 1'b1);
    drain("latency");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
